// File: rtl/booth_sequencer.sv
// Control sequencer for a radix-2 Booth multiplier datapath.
// Issues load / add-sub / arithmetic-shift commands and a start/busy/done handshake.
module booth_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             q0,
  input  logic             qm1,
  output logic             m_ctrl,
  output logic [1:0]       a_ctrl,
  output logic [1:0]       q_ctrl,
  output logic [1:0]       qm1_ctrl,
  output logic             alu_op,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_LOAD:  count <= CNT_W'(WIDTH);
        S_SHIFT: count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Outputs are pure state decode, except EVAL which also looks at {q0,qm1}.
  always_comb begin
    state_next = state;
    m_ctrl     = 1'b0;
    a_ctrl     = 2'b00;
    q_ctrl     = 2'b00;
    qm1_ctrl   = 2'b00;
    alu_op     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        m_ctrl     = 1'b1;
        a_ctrl     = 2'b01;
        q_ctrl     = 2'b01;
        qm1_ctrl   = 2'b01;
        busy       = 1'b1;
        state_next = S_EVAL;
      end
      S_EVAL: begin
        busy = 1'b1;
        case ({q0, qm1})
          2'b10: begin
            a_ctrl = 2'b10;
            alu_op = 1'b1;
          end
          2'b01: begin
            a_ctrl = 2'b10;
            alu_op = 1'b0;
          end
          default: a_ctrl = 2'b00;
        endcase
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        a_ctrl     = 2'b11;
        q_ctrl     = 2'b11;
        qm1_ctrl   = 2'b11;
        busy       = 1'b1;
        state_next = (count == CNT_W'(1)) ? S_DONE : S_EVAL;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
